// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel, WIDTH-bit arbitrating multiplexer with valid/ready
// handshakes on every channel and a one-beat registered output stage.
// The winner is picked round-robin (RR=1) or by lowest index (RR=0), and
// its index is reported alongside the data.
module rr_mux_arb #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int RR    = 1,
  localparam int SW   = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SW-1:0]      out_sel
);

  // Output register and round-robin pointer.
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [SW-1:0]    out_sel_q, out_sel_d;
  logic [SW-1:0]    last_q, last_d;

  // Arbitration intermediates.
  logic             load_en;
  logic             arb_en;
  logic             lo_found, hi_found;
  logic [SW-1:0]    lo_idx, hi_idx, gnt_idx;
  logic [WIDTH-1:0] gnt_data;

  // The output register can take a new beat when it is empty or being drained.
  assign load_en = ~out_valid_q | out_ready;

  // NOTE: rst_n gates the grant so in_ready stays low for the whole reset,
  // even though the emptied output register would otherwise accept a beat.
  assign arb_en = rst_n & load_en & (|in_valid);

  // Find the lowest requester overall and the lowest requester above the
  // pointer; round-robin prefers the latter and wraps to the former, which
  // keeps the search exact for non-power-of-two N.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned and no latch is inferred.
    lo_found = 1'b0;
    lo_idx   = '0;
    hi_found = 1'b0;
    hi_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
      end
      if (in_valid[i] && !hi_found && (i > int'(last_q))) begin
        hi_found = 1'b1;
        hi_idx   = SW'(i);
      end
    end
    gnt_idx = ((RR != 0) && hi_found) ? hi_idx : lo_idx;
  end

  // Decode the grant into the one-hot accept and mux out the winner's data.
  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) begin
        in_ready[i] = arb_en;
        gnt_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next state: load on transfer, clear valid on a plain drain, else hold.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (arb_en) begin
      out_data_d  = gnt_data;
      out_sel_d   = gnt_idx;
      out_valid_d = 1'b1;
      if (RR != 0) begin
        last_d = gnt_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset empties the stage and points priority at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SW'(N - 1);
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: scoreboard bench for rr_mux_arb. A round-robin instance
// (N=4) is driven with directed and random traffic against a reference
// model; a fixed-priority N=3 instance covers the non-power-of-two case.
module tb_rr_mux_arb;

  localparam int W    = 16;
  localparam int N    = 4;
  localparam int N3   = 3;
  localparam int HALF = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #HALF clk = ~clk;

  // Round-robin instance.
  logic [N*W-1:0] in_data   = '0;
  logic [N-1:0]   in_valid  = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     out_sel;

  // Fixed-priority, three-channel instance.
  logic [N3*W-1:0] fp_data      = '0;
  logic [N3-1:0]   fp_valid     = '0;
  logic [N3-1:0]   fp_ready;
  logic [W-1:0]    fp_out_data;
  logic            fp_out_valid;
  logic            fp_out_ready = 1'b1;
  logic [1:0]      fp_out_sel;

  rr_mux_arb #(.WIDTH(W), .N(N), .RR(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  rr_mux_arb #(.WIDTH(W), .N(N3), .RR(0)) dut_fp (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (fp_data),
    .in_valid  (fp_valid),
    .in_ready  (fp_ready),
    .out_data  (fp_out_data),
    .out_valid (fp_out_valid),
    .out_ready (fp_out_ready),
    .out_sel   (fp_out_sel)
  );

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } beat_t;

  beat_t sb[$];
  int    m_last = N - 1;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: walk channels in priority order with modulo arithmetic.
  function automatic int pick(input logic [3:0] v, input int last, input int n, input bit rr);
    int c;
    for (int k = 1; k <= n; k++) begin
      c = rr ? (last + k) % n : k - 1;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: whatever sits in the output register must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", out_valid, sb.size() != 0);
      if (sb.size() != 0) begin
        check("out_sel", out_sel, sb[0].sel);
        check("out_data", out_data, sb[0].data);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // One cycle of stimulus; entered and left just after a rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic r, input bit rnd);
    int          g;
    logic [63:0] exp_rdy;
    if (rnd) for (int i = 0; i < N; i++) in_data[i*W +: W] = W'($urandom);
    in_valid  = v;
    out_ready = r;
    @(negedge clk);
    #1;
    exp_rdy = '0;
    // The stage accepts only when the beat it holds (if any) leaves this cycle.
    if (sb.size() == 0) begin
      g = pick(v, m_last, N, 1'b1);
      if (g >= 0) begin
        exp_rdy = 64'd1 << g;
        sb.push_back('{sel: 2'(g), data: W'(in_data >> (g * W))});
        m_last = g;
      end
    end
    check("in_ready", in_ready, exp_rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic set_pattern_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(16'hA000 + i);
  endtask

  initial begin
    int g;
    int prev_g;

    // Reset / idle with every channel requesting.
    set_pattern_data();
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin fairness: 0,1,2,3,0,1,2,3.
    repeat (8) cycle(4'b1111, 1'b1, 1'b0);

    // Sparse requests wrapping past the last grant of channel 3: 1,3,1.
    repeat (3) cycle(4'b1010, 1'b1, 1'b0);

    // Backpressure while holding channel 2's beat; channel 3 wins afterwards.
    cycle(4'b0100, 1'b1, 1'b0);
    repeat (3) cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0);

    // Random traffic with random backpressure.
    repeat (400) cycle(N'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0);

    // Asynchronous reset mid-operation while channel 1's beat is stalled.
    set_pattern_data();
    cycle(4'b0010, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_in_ready", in_ready, 0);
    sb.delete();
    m_last = N - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) cycle(4'b1111, 1'b1, 1'b0);
    repeat (2) cycle(4'b0000, 1'b1, 1'b0);

    // Fixed priority, three channels: 1 while 3'b110, then 0 with channel 2 starved.
    for (int i = 0; i < N3; i++) fp_data[i*W +: W] = W'(16'hB000 + i);
    prev_g = -1;
    for (int c = 0; c < 8; c++) begin
      fp_valid = (c < 3) ? 3'b110 : 3'b111;
      g = pick({1'b0, fp_valid}, 0, N3, 1'b0);
      @(negedge clk);
      #1;
      check("fp_in_ready", fp_ready, 64'd1 << g);
      if (prev_g >= 0) begin
        check("fp_out_valid", fp_out_valid, 1);
        check("fp_out_sel", fp_out_sel, prev_g);
        check("fp_out_data", fp_out_data, 16'hB000 + prev_g);
      end
      prev_g = g;
      @(posedge clk);
      #1;
    end
    fp_valid = '0;

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
